// File: rtl/osnt_ts_pkg.sv
// Shared constants and types for the receive-side timestamp inserter.
// Widths, ts_pos field positions and the packet-tracking state encoding.
package osnt_ts_pkg;

    localparam int DATA_W    = 256;
    localparam int KEEP_W    = DATA_W / 8;
    localparam int USER_W    = 128;
    localparam int TS_W      = 64;
    localparam int PAYLOAD_W = DATA_W + KEEP_W + USER_W + 1;

    localparam int EN_BIT = 31;
    localparam int OFF_HI = 15;
    localparam int OFF_LO = 3;

    localparam int BEAT_W = OFF_HI - OFF_LO - 1;
    localparam int LANE_W = 2;

    typedef enum logic {
        SOF = 1'b0,
        MID = 1'b1
    } pkt_state_e;

    // True when every byte of the selected 64-bit lane is valid.
    function automatic logic lane_full(input logic [KEEP_W-1:0] keep,
                                       input logic [LANE_W-1:0] lane);
        return &keep[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/axis_skid_slice.sv
// One-stage AXI-Stream register slice with a one-entry skid buffer.
// Input ready is registered, so there is no combinational path from m_ready_i.
module axis_skid_slice #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] s_data_i,
    input  logic         s_valid_i,
    output logic         s_ready_o,
    output logic [W-1:0] m_data_o,
    output logic         m_valid_o,
    input  logic         m_ready_i
);

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q,  out_data_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] skid_data_q,  skid_data_d;
    logic         ready_q;
    logic         in_fire;

    // Valid/ready: a beat moves on either side only when valid && ready are
    // both high at the rising edge; valid never depends on ready.
    assign s_ready_o = ready_q & ~rst_i;
    assign in_fire   = s_valid_i & s_ready_o;
    assign m_data_o  = out_data_q;
    assign m_valid_o = out_valid_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (!out_valid_q || m_ready_i) begin
            // Skid content always drains first; input is blocked while it is full.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_fire;
                if (in_fire) begin
                    out_data_d = s_data_i;
                end
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = s_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            ready_q      <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            ready_q      <= ~skid_valid_d;
        end
    end

endmodule

// File: rtl/osnt_sume_ts_inserter.sv
// Receive timestamp inserter: captures stamp_counter at each packet's first beat
// and overwrites one 8-byte lane at the configured offset, with insert/miss stats.
module osnt_sume_ts_inserter
    import osnt_ts_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = DATA_W,
    parameter int C_AXIS_TUSER_WIDTH = USER_W,
    parameter int TIMESTAMP_WIDTH    = TS_W
) (
    input  logic                            axi_aclk,
    input  logic                            axi_reset,
    input  logic [TIMESTAMP_WIDTH-1:0]      stamp_counter,
    input  logic [31:0]                     ts_pos,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready,
    output logic [31:0]                     ts_insert_count,
    output logic [31:0]                     ts_miss_count
);

    localparam int KW = C_AXIS_DATA_WIDTH / 8;
    localparam int PW = C_AXIS_DATA_WIDTH + KW + C_AXIS_TUSER_WIDTH + 1;

    pkt_state_e                 state_q, state_d;
    logic [BEAT_W-1:0]          beat_cnt_q, beat_cnt_d;
    logic                       en_q, en_d;
    logic [BEAT_W-1:0]          bsel_q, bsel_d;
    logic [LANE_W-1:0]          lane_q, lane_d;
    logic [TIMESTAMP_WIDTH-1:0] ts_hold_q, ts_hold_d;
    logic                       inserted_q, inserted_d;
    logic [31:0]                insert_cnt_q, insert_cnt_d;
    logic [31:0]                miss_cnt_q, miss_cnt_d;

    logic                         in_fire;
    logic                         sof;
    logic                         cur_en;
    logic [BEAT_W-1:0]            cur_bsel;
    logic [LANE_W-1:0]            cur_lane;
    logic [TIMESTAMP_WIDTH-1:0]   cur_ts;
    logic [BEAT_W-1:0]            beat_idx;
    logic                         already;
    logic                         hit;
    logic [C_AXIS_DATA_WIDTH-1:0] tdata_mod;
    logic [PW-1:0]                slice_in;
    logic [PW-1:0]                slice_out;
    logic                         unused_cfg_bits;

    assign unused_cfg_bits = ^{ts_pos[EN_BIT-1:OFF_HI+1], ts_pos[OFF_LO-1:0]};
    assign in_fire         = s_axis_tvalid & s_axis_tready;

    // On the SOF beat the live config and counter apply; later beats use the latched copy.
    always_comb begin
        sof      = (state_q == SOF);
        cur_en   = sof ? ts_pos[EN_BIT]                  : en_q;
        cur_bsel = sof ? ts_pos[OFF_HI:OFF_LO+LANE_W]    : bsel_q;
        cur_lane = sof ? ts_pos[OFF_LO+LANE_W-1:OFF_LO]  : lane_q;
        cur_ts   = sof ? stamp_counter                   : ts_hold_q;
        beat_idx = sof ? '0                              : beat_cnt_q;
        already  = ~sof & inserted_q;
        hit      = cur_en & ~already & (beat_idx == cur_bsel)
                   & lane_full(s_axis_tkeep, cur_lane);

        tdata_mod = s_axis_tdata;
        if (hit) begin
            tdata_mod[{cur_lane, 6'b000000} +: TIMESTAMP_WIDTH] = cur_ts;
        end
    end

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        en_d         = en_q;
        bsel_d       = bsel_q;
        lane_d       = lane_q;
        ts_hold_d    = ts_hold_q;
        inserted_d   = inserted_q;
        insert_cnt_d = insert_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        if (in_fire) begin
            state_d    = s_axis_tlast ? SOF : MID;
            beat_cnt_d = (&beat_idx) ? beat_idx : beat_idx + 1'b1;
            inserted_d = already | hit;
            if (sof) begin
                en_d      = cur_en;
                bsel_d    = cur_bsel;
                lane_d    = cur_lane;
                ts_hold_d = cur_ts;
            end
            if (hit) begin
                insert_cnt_d = insert_cnt_q + 32'd1;
            end
            // A miss needs no insertion anywhere in the packet, including this beat.
            if (s_axis_tlast && cur_en && !already && !hit) begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state_q      <= SOF;
            beat_cnt_q   <= '0;
            en_q         <= 1'b0;
            bsel_q       <= '0;
            lane_q       <= '0;
            ts_hold_q    <= '0;
            inserted_q   <= 1'b0;
            insert_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            en_q         <= en_d;
            bsel_q       <= bsel_d;
            lane_q       <= lane_d;
            ts_hold_q    <= ts_hold_d;
            inserted_q   <= inserted_d;
            insert_cnt_q <= insert_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign slice_in = {tdata_mod, s_axis_tkeep, s_axis_tuser, s_axis_tlast};

    axis_skid_slice #(
        .W (PW)
    ) u_slice (
        .clk_i     (axi_aclk),
        .rst_i     (axi_reset),
        .s_data_i  (slice_in),
        .s_valid_i (s_axis_tvalid),
        .s_ready_o (s_axis_tready),
        .m_data_o  (slice_out),
        .m_valid_o (m_axis_tvalid),
        .m_ready_i (m_axis_tready)
    );

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = slice_out;
    assign ts_insert_count = insert_cnt_q;
    assign ts_miss_count   = miss_cnt_q;

endmodule

// File: tb/tb_osnt_sume_ts_inserter.sv
// Scoreboard bench for osnt_sume_ts_inserter: directed packets, random backpressure,
// reset behaviour and a mid-packet reset.
module tb_osnt_sume_ts_inserter;
  import osnt_ts_pkg::*;

  localparam int W = PAYLOAD_W;

  // ---------------- clock / reset ----------------
  logic axi_aclk = 1'b0;
  always #5 axi_aclk = ~axi_aclk;

  logic         axi_reset = 1'b1;
  logic [63:0]  stamp_counter = '0;
  logic [31:0]  ts_pos = '0;
  logic [255:0] s_axis_tdata = '0;
  logic [31:0]  s_axis_tkeep = '0;
  logic [127:0] s_axis_tuser = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tlast = 1'b0;
  logic         s_axis_tready;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tkeep;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tlast;
  logic         m_axis_tready;
  logic [31:0]  ts_insert_count;
  logic [31:0]  ts_miss_count;

  osnt_sume_ts_inserter dut (
    .axi_aclk        (axi_aclk),
    .axi_reset       (axi_reset),
    .stamp_counter   (stamp_counter),
    .ts_pos          (ts_pos),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tkeep    (s_axis_tkeep),
    .s_axis_tuser    (s_axis_tuser),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tready   (s_axis_tready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tkeep    (m_axis_tkeep),
    .m_axis_tuser    (m_axis_tuser),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tready   (m_axis_tready),
    .ts_insert_count (ts_insert_count),
    .ts_miss_count   (ts_miss_count)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0]   exp_q[$];
  logic [255:0]   obs_q[$];
  int exp_ins = 0;
  int exp_miss = 0;
  logic bp_mode = 1'b0;
  logic [W-1:0] mon_got, mon_exp;
  logic desired_rdy, gl_a, gl_b;
  logic [255:0] tmp;
  logic [31:0] pos_tab [0:5];
  logic [31:0] keep_tab [0:3];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge axi_aclk) begin
    if (m_axis_tvalid && m_axis_tready) begin
      mon_got = {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
      obs_q.push_back(m_axis_tdata);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat got=%h exp=none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL out_beat got=%h exp=%h", mon_got, mon_exp);
        end
      end
    end
  end

  // ---------------- downstream ready driver ----------------
  // Under backpressure the ready line is briefly driven to the opposite value;
  // s_axis_tready must not move with it.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge axi_aclk);
      #1;
      if (bp_mode) begin
        desired_rdy = ($urandom_range(0, 9) >= 3);
        m_axis_tready = ~desired_rdy;
        #1 gl_a = s_axis_tready;
        m_axis_tready = desired_rdy;
        #1 gl_b = s_axis_tready;
        chk("s_tready_comb_path", {63'b0, gl_a}, {63'b0, gl_b});
      end else begin
        m_axis_tready = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [255:0] d, input logic [31:0] k, input logic [127:0] u,
                           input logic l, input logic [63:0] st, input logic [31:0] pos);
    int n;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    stamp_counter = st;
    ts_pos        = pos;
    s_axis_tvalid = 1'b1;
    n = 0;
    @(negedge axi_aclk);
    while (!s_axis_tready && n < 200) begin
      n++;
      @(negedge axi_aclk);
    end
    if (!s_axis_tready) begin
      checks++;
      errors++;
      $display("FAIL s_tready_timeout got=0 after %0d cycles exp=1", n);
    end
    @(posedge axi_aclk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  // Expected beat built from the intended behaviour: config and stamp captured at SOF.
  task automatic send_pkt(input int nb, input logic [31:0] pos_sof, input logic [31:0] pos_mid,
                          input logic [63:0] stamp0, input logic [31:0] last_keep);
    logic en, ins, l;
    logic [10:0] bsel;
    logic [1:0] lane;
    logic [63:0] hold;
    logic [255:0] d, ed;
    logic [31:0] k;
    logic [127:0] u;
    en   = pos_sof[31];
    bsel = pos_sof[15:5];
    lane = pos_sof[4:3];
    hold = stamp0;
    ins  = 1'b0;
    for (int i = 0; i < nb; i++) begin
      d  = rnd256();
      u  = rnd128();
      l  = (i == nb - 1);
      k  = l ? last_keep : 32'hFFFF_FFFF;
      ed = d;
      if (en && !ins && (11'(i) == bsel) && (&k[{lane, 3'b000} +: 8])) begin
        ed[{lane, 6'b000000} +: 64] = hold;
        ins = 1'b1;
        exp_ins++;
      end
      if (l && en && !ins) exp_miss++;
      exp_q.push_back({ed, k, u, l});
      send_beat(d, k, u, l, stamp0 + 64'(i) * 64'h1000, (i == 0) ? pos_sof : pos_mid);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge axi_aclk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got=%0d pending exp=0", exp_q.size());
    end
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic apply_reset();
    axi_reset = 1'b1;
    s_axis_tvalid = 1'b0;
    repeat (2) @(posedge axi_aclk);
    @(negedge axi_aclk);
    chk("rst_m_tvalid", {63'b0, m_axis_tvalid}, 64'd0);
    chk("rst_s_tready", {63'b0, s_axis_tready}, 64'd0);
    chk("rst_m_fields", {63'b0, |{m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast}}, 64'd0);
    chk("rst_insert_cnt", 64'(ts_insert_count), 64'd0);
    chk("rst_miss_cnt", 64'(ts_miss_count), 64'd0);
    @(posedge axi_aclk);
    #1;
    axi_reset = 1'b0;
    exp_q.delete();
    obs_q.delete();
    exp_ins = 0;
    exp_miss = 0;
    @(posedge axi_aclk);
    @(negedge axi_aclk);
    chk("post_rst_s_tready", {63'b0, s_axis_tready}, 64'd1);
    @(posedge axi_aclk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    pos_tab[0] = 32'h8000_0008;
    pos_tab[1] = 32'h8000_0048;
    pos_tab[2] = 32'h8000_0100;
    pos_tab[3] = 32'h0000_0008;
    pos_tab[4] = 32'h8000_0018;
    pos_tab[5] = 32'h8000_0020;
    keep_tab[0] = 32'hFFFF_FFFF;
    keep_tab[1] = 32'h0000_FFFF;
    keep_tab[2] = 32'h00FF_FFFF;
    keep_tab[3] = 32'h0000_00FF;

    // Insert at offset 8: beat 0, lane 1.
    apply_reset();
    send_pkt(2, 32'h8000_0008, 32'h8000_0008, 64'h0123_4567_89AB_CDEF, 32'hFFFF_FFFF);
    wait_drain();
    tmp = obs_q[0];
    chk("t1_ts_lane1", tmp[127:64], 64'h0123_4567_89AB_CDEF);
    chk("t1_insert_cnt", 64'(ts_insert_count), 64'd1);
    chk("t1_miss_cnt", 64'(ts_miss_count), 64'd0);

    // Offset 0x48: beat 2, lane 1, must carry the SOF-cycle stamp.
    apply_reset();
    send_pkt(4, 32'h8000_0048, 32'h8000_0048, 64'hAAAA_0000_0000_0000, 32'hFFFF_FFFF);
    wait_drain();
    tmp = obs_q[2];
    chk("t2_sof_stamp", tmp[127:64], 64'hAAAA_0000_0000_0000);
    chk("t2_insert_cnt", 64'(ts_insert_count), 64'd1);
    chk("t2_miss_cnt", 64'(ts_miss_count), 64'd0);

    // Packet ends before beat 8.
    apply_reset();
    send_pkt(2, 32'h8000_0100, 32'h8000_0100, 64'h1111_2222_3333_4444, 32'hFFFF_FFFF);
    wait_drain();
    chk("t3_insert_cnt", 64'(ts_insert_count), 64'd0);
    chk("t3_miss_cnt", 64'(ts_miss_count), 64'd1);

    // Disabled at SOF, enabled mid-packet: no effect until next packet.
    apply_reset();
    send_pkt(2, 32'h0000_0008, 32'h8000_0008, 64'h9999_8888_7777_6666, 32'hFFFF_FFFF);
    wait_drain();
    chk("t4_dis_insert_cnt", 64'(ts_insert_count), 64'd0);
    chk("t4_dis_miss_cnt", 64'(ts_miss_count), 64'd0);
    send_pkt(2, 32'h8000_0008, 32'h8000_0008, 64'h2222_3333_4444_5555, 32'hFFFF_FFFF);
    wait_drain();
    tmp = obs_q[2];
    chk("t4_next_pkt_ts", tmp[127:64], 64'h2222_3333_4444_5555);
    chk("t4_insert_cnt", 64'(ts_insert_count), 64'd1);

    // Lane 3 partially kept -> miss; then fully kept -> insert. Also 1-cycle latency.
    apply_reset();
    send_pkt(1, 32'h8000_0018, 32'h8000_0018, 64'h3333_3333_3333_3333, 32'h00FF_FFFF);
    @(negedge axi_aclk);
    chk("t5_latency_tvalid", {63'b0, m_axis_tvalid}, 64'd1);
    wait_drain();
    chk("t5_partial_miss_cnt", 64'(ts_miss_count), 64'd1);
    chk("t5_partial_insert_cnt", 64'(ts_insert_count), 64'd0);
    send_pkt(1, 32'h8000_0018, 32'h8000_0018, 64'h4444_5555_6666_7777, 32'hFFFF_FFFF);
    wait_drain();
    tmp = obs_q[1];
    chk("t5_lane3_ts", tmp[255:192], 64'h4444_5555_6666_7777);
    chk("t5_insert_cnt", 64'(ts_insert_count), 64'd1);
    chk("t5_miss_cnt", 64'(ts_miss_count), 64'd1);

    // Random backpressure across many packets.
    apply_reset();
    bp_mode = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      send_pkt($urandom_range(1, 5), pos_tab[$urandom_range(0, 5)], pos_tab[$urandom_range(0, 5)],
               {$urandom(), $urandom()}, keep_tab[$urandom_range(0, 3)]);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge axi_aclk);
        #1;
      end
    end
    bp_mode = 1'b0;
    wait_drain();
    chk("bp_insert_cnt", 64'(ts_insert_count), 64'(exp_ins));
    chk("bp_miss_cnt", 64'(ts_miss_count), 64'(exp_miss));

    // Reset on beat 1 of a 3-beat packet.
    apply_reset();
    send_pkt(1, 32'h8000_0000, 32'h8000_0000, 64'h0F0F_0F0F_0F0F_0F0F, 32'hFFFF_FFFF);
    wait_drain();
    chk("t7_pre_insert_cnt", 64'(ts_insert_count), 64'd1);
    tmp = rnd256();
    exp_q.push_back({tmp, 32'hFFFF_FFFF, 128'h0, 1'b0});
    send_beat(tmp, 32'hFFFF_FFFF, 128'h0, 1'b0, 64'h7777_7777_7777_7777, 32'h8000_0048);
    axi_reset = 1'b1;
    s_axis_tdata = rnd256();
    s_axis_tlast = 1'b0;
    s_axis_tvalid = 1'b1;
    @(posedge axi_aclk);
    #1;
    axi_reset = 1'b0;
    s_axis_tvalid = 1'b0;
    @(negedge axi_aclk);
    chk("t7_m_tvalid", {63'b0, m_axis_tvalid}, 64'd0);
    chk("t7_insert_cnt", 64'(ts_insert_count), 64'd0);
    chk("t7_miss_cnt", 64'(ts_miss_count), 64'd0);
    chk("t7_beat0_out", 64'(exp_q.size()), 64'd0);
    obs_q.delete();
    exp_ins = 0;
    exp_miss = 0;
    @(posedge axi_aclk);
    #1;
    send_pkt(1, 32'h8000_0000, 32'h8000_0000, 64'h5A5A_A5A5_1234_5678, 32'hFFFF_FFFF);
    wait_drain();
    tmp = obs_q[0];
    chk("t7_single_ts", tmp[63:0], 64'h5A5A_A5A5_1234_5678);
    chk("t7_single_insert_cnt", 64'(ts_insert_count), 64'd1);
    chk("t7_single_miss_cnt", 64'(ts_miss_count), 64'd0);

    repeat (3) @(posedge axi_aclk);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
